// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, status bytes, dispatcher states and CRC-8 step shared by the command path
package cmd_pkg;
  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_CRC       = 8'hE1;
  localparam logic [7:0] ST_BADCMD    = 8'hE2;
  localparam logic [7:0] ST_TIMEOUT   = 8'hE3;
  localparam logic [7:0] CRC8_POLY    = 8'h07;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MEM, S_RESP} state_t;
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/crc8_3byte.sv
// crc8_3byte: combinational CRC-8 (MSB first, init 0) over three bytes
module crc8_3byte
  import cmd_pkg::*;
(
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  output logic [7:0] crc
);
  assign crc = crc8_step(crc8_step(crc8_step(8'h00, b0), b1), b2);
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: CRC-checks host command frames, runs them on the cart memory bus, returns one status byte each
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  cmd,
  input  logic [7:0]  arg1,
  input  logic [7:0]  arg2,
  input  logic [7:0]  crc,
  input  logic        frame_finished,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  resp_byte,
  output logic        resp_toggle,
  output logic        busy,
  output logic        overrun
);
  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);
  state_t state, state_nx;
  logic prev_frame, new_frame;
  logic [7:0] f_cmd, f_a1, f_a2, f_crc, crc_calc, cnt, cnt_nx, resp_nx;
  logic [15:0] ptr, ptr_nx;
  assign new_frame = en & (frame_finished ^ prev_frame);
  assign busy = state != S_IDLE;
  assign mem_req = state == S_MEM;
  assign mem_we = mem_req & (f_cmd == CMD_WRITE);
  assign mem_addr = ptr;
  assign mem_wdata = mem_req ? f_a1 : 8'h00;
  crc8_3byte u_crc (.b0(f_cmd), .b1(f_a1), .b2(f_a2), .crc(crc_calc));
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    cnt_nx = cnt;
    resp_nx = resp_byte;
    case (state)
      S_IDLE: state_nx = new_frame ? S_CHECK : S_IDLE;
      S_CHECK: begin
        state_nx = S_RESP;
        cnt_nx = 8'h00;
        if (crc_calc != f_crc) resp_nx = ST_CRC;
        else if (f_cmd == CMD_WRITE || f_cmd == CMD_READ) state_nx = S_MEM;
        else begin
          resp_nx = (f_cmd == CMD_NOP || f_cmd == CMD_SET_ADDR) ? ST_OK : ST_BADCMD;
          ptr_nx = (f_cmd == CMD_SET_ADDR) ? {f_a1, f_a2} : ptr;
        end
      end
      S_MEM: begin
        cnt_nx = cnt + 8'd1;
        // an ack on the final allowed cycle still wins over the timeout
        if (mem_ack) begin
          state_nx = S_RESP;
          ptr_nx = ptr + 16'd1;
          resp_nx = mem_we ? ST_OK : mem_rdata;
        end else if (cnt_nx == TMO) begin
          state_nx = S_RESP;
          resp_nx = ST_TIMEOUT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr <= 16'h0000;
      cnt <= 8'h00;
      resp_byte <= 8'h00;
      resp_toggle <= 1'b0;
      overrun <= 1'b0;
      {f_cmd, f_a1, f_a2, f_crc} <= 32'h0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      resp_byte <= resp_nx;
      resp_toggle <= resp_toggle ^ (state_nx == S_RESP);
      overrun <= overrun | (new_frame & busy);
      if (new_frame && !busy) {f_cmd, f_a1, f_a2, f_crc} <= {cmd, arg1, arg2, crc};
    end
  end
  // tracking the live toggle level through reset keeps a held level from looking like a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_frame <= frame_finished;
    else if (new_frame) prev_frame <= frame_finished;
  end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed and randomized frames checked against a behavioural command/memory model
module tb_cmd_dispatcher;
  localparam int T = 20;
  logic clk = 1'b0, reset, en, frame_finished, mem_ack;
  logic [7:0] cmd, arg1, arg2, crc, mem_rdata, mem_wdata, resp_byte;
  logic mem_req, mem_we, resp_toggle, busy, overrun;
  logic [15:0] mem_addr;
  int nvec = 0, nerr = 0;
  logic [15:0] ptr_m;
  logic [7:0] mem_m [int];

  cmd_dispatcher #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .en(en), .cmd(cmd), .arg1(arg1), .arg2(arg2), .crc(crc),
    .frame_finished(frame_finished), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resp_byte(resp_byte),
    .resp_toggle(resp_toggle), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of message * x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [31:0] m;
    m = {a, b, c, 8'h00};
    for (int i = 31; i >= 8; i--) if (m[i]) m = m ^ (32'h107 << (i - 8));
    return m[7:0];
  endfunction

  task automatic run_cmd(input logic [7:0] c, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] cr, input int delay, input int extra_at);
    logic t0, done;
    logic [7:0] er, rd_val;
    logic [15:0] eaddr;
    int ereq, lat, reqs;
    eaddr = ptr_m;
    ereq = 0;
    er = 8'h00;
    rd_val = 8'h00;
    if (crc_of(c, a1, a2) !== cr) er = 8'hE1;
    else if (c == 8'h01) ptr_m = {a1, a2};
    else if (c == 8'h02 || c == 8'h03) begin
      if (!mem_m.exists(int'(ptr_m))) mem_m[int'(ptr_m)] = 8'($urandom);
      rd_val = mem_m[int'(ptr_m)];
      if (delay < T) begin
        ereq = delay + 1;
        er = (c == 8'h03) ? rd_val : 8'h00;
        if (c == 8'h02) mem_m[int'(ptr_m)] = a1;
        ptr_m = ptr_m + 16'd1;
      end else begin
        ereq = T;
        er = 8'hE3;
      end
    end else if (c != 8'h00) er = 8'hE2;
    t0 = resp_toggle;
    @(negedge clk);
    cmd = c; arg1 = a1; arg2 = a2; crc = cr;
    frame_finished = ~frame_finished;
    lat = 0; reqs = 0; done = 1'b0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (lat == extra_at) frame_finished = ~frame_finished;
      chk("busy_during", busy, 1'b1);
      if (mem_req) begin
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_we", mem_we, c == 8'h02);
        if (c == 8'h02) chk("mem_wdata", mem_wdata, a1);
        if (reqs == delay) begin
          mem_ack = 1'b1;
          mem_rdata = rd_val;
        end
        reqs++;
      end
      if (resp_toggle !== t0) done = 1'b1;
    end
    chk("resp_seen", done, 1'b1);
    chk("latency", lat, (ereq == 0) ? 2 : ereq + 2);
    chk("req_cycles", reqs, ereq);
    chk("resp_byte", resp_byte, er);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("busy_after", busy, 1'b0);
    chk("req_after", mem_req, 1'b0);
  endtask

  initial begin
    logic t;
    reset = 1'b1; en = 1'b1; frame_finished = 1'b0;
    cmd = 8'h00; arg1 = 8'h00; arg2 = 8'h00; crc = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_resp_toggle", resp_toggle, 1'b0);
    chk("rst_resp_byte", resp_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    reset = 1'b0;
    ptr_m = 16'h0000;
    @(negedge clk);
    run_cmd(8'h01, 8'h12, 8'h34, 8'h9A, 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 0, -1);
    run_cmd(8'h01, 8'h12, 8'h34, 8'h9A, 0, -1);
    run_cmd(8'h02, 8'h5A, 8'h00, 8'h58, 3, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 1, -1);
    run_cmd(8'h01, 8'h12, 8'h34, 8'h9A, 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 2, -1);
    run_cmd(8'h01, 8'h12, 8'h34, 8'h00, 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 0, -1);
    run_cmd(8'h7F, 8'h00, 8'h00, crc_of(8'h7F, 8'h00, 8'h00), 0, -1);
    run_cmd(8'h01, 8'hFF, 8'hFF, crc_of(8'h01, 8'hFF, 8'hFF), 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 1, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 1000, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 0, -1);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, T - 1, -1);
    run_cmd(8'h02, 8'h77, 8'h00, crc_of(8'h02, 8'h77, 8'h00), T, -1);
    en = 1'b0;
    @(negedge clk);
    frame_finished = ~frame_finished;
    repeat (4) @(negedge clk);
    chk("en_low_busy", busy, 1'b0);
    chk("en_low_req", mem_req, 1'b0);
    frame_finished = ~frame_finished;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_high_busy", busy, 1'b0);
    for (int i = 0; i < 200; i++) begin
      int k, k2, d;
      logic [7:0] c, a1, a2, cr;
      k = $urandom_range(0, 99);
      k2 = $urandom_range(0, 19);
      a1 = 8'($urandom);
      a2 = 8'($urandom);
      if (k < 15) begin
        c = 8'h01;
        if (k < 4) begin a1 = 8'hFF; a2 = 8'($urandom_range(254, 255)); end
      end else if (k < 45) c = 8'h02;
      else if (k < 75) c = 8'h03;
      else if (k < 83) c = 8'h00;
      else c = 8'(4 + $urandom_range(0, 251));
      cr = crc_of(c, a1, a2);
      if ($urandom_range(0, 9) == 0) cr = cr ^ 8'($urandom_range(1, 255));
      d = (k2 == 0) ? T - 1 : (k2 == 1) ? 1000 : $urandom_range(0, 4);
      run_cmd(c, a1, a2, cr, d, -1);
    end
    chk("no_overrun_yet", overrun, 1'b0);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 5, 3);
    chk("overrun_mem", overrun, 1'b1);
    t = resp_toggle;
    repeat (10) @(negedge clk);
    chk("single_resp", resp_toggle, t);
    chk("dropped_idle", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 16'h0000;
    chk("overrun_cleared", overrun, 1'b0);
    run_cmd(8'h00, 8'h00, 8'h00, 8'h00, 0, 2);
    chk("overrun_resp_exit", overrun, 1'b1);
    run_cmd(8'h01, 8'hAB, 8'hCD, crc_of(8'h01, 8'hAB, 8'hCD), 0, -1);
    @(negedge clk);
    cmd = 8'h03; arg1 = 8'h00; arg2 = 8'h00; crc = 8'hBD;
    frame_finished = ~frame_finished;
    repeat (4) @(negedge clk);
    chk("mid_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_drop_req", mem_req, 1'b0);
    chk("rst_no_resp", resp_toggle, 1'b0);
    chk("rst_busy_mid", busy, 1'b0);
    frame_finished = ~frame_finished;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = 16'h0000;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_req", mem_req, 1'b0);
    chk("post_rst_toggle", resp_toggle, 1'b0);
    run_cmd(8'h03, 8'h00, 8'h00, 8'hBD, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
